dm_access_unit: RTL
===================

DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 Parameter SPLIT_EN, default 1: 1 = misaligned accesses are split into two word beats; 0 = misaligned accesses complete with rsp_err.
REQ-002 Clock is clk, reset is rstn; one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rstn  in  1  synchronous active-low reset.
REQ-005 req_valid  in  1  pipeline memory request present (MemRead or MemWrite).
REQ-006 req_ready  out  1  unit can accept a request.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_dmtype  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_err  out  1  completion carries an error; valid only with rsp_valid.
REQ-013 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 mem_en  out  1  word SRAM access strobe.
REQ-015 mem_we  out  1  SRAM write.
REQ-016 mem_be  out  4  SRAM byte enables.
REQ-017 mem_addr  out  30  SRAM word address.
REQ-018 mem_wdata  out  32  SRAM write data.
REQ-019 mem_rdata  in  32  SRAM read data, valid the cycle after a read strobe.

Function
REQ-020 FSM states IDLE, BEAT0, BEAT1, DONE; req_ready = 1 only in IDLE.
REQ-021 Accept on req_valid & req_ready; latch we, dmtype, addr, wdata; off = addr[1:0], w0 = addr[31:2].
REQ-022 Lane mask: size mask (word 1111, half 0011, byte 0001) zero-extended to 8 bits, shifted left by off; lane data: wdata zero-extended to 64 bits, shifted left by 8*off.
REQ-023 Split = lane mask bits [7:4] nonzero (word off 1-3, half off 3).
REQ-024 Invalid dmtype (101-111), or split with SPLIT_EN = 0: IDLE -> DONE, no mem_en, rsp_err = 1.
REQ-025 BEAT0: mem_en = 1, mem_we = we, mem_addr = w0, mem_be = mask[3:0], mem_wdata = lane[31:0]; -> BEAT1 if split, else DONE.
REQ-026 BEAT1: mem_en = 1, mem_addr = w0 + 1 (mod 2^30, wraps to 0), mem_be = mask[7:4], mem_wdata = lane[63:32]; BEAT1 captures mem_rdata into lo register; -> DONE.
REQ-027 DONE: rsp_valid = 1 for exactly one cycle; -> IDLE.
REQ-028 Load data assembly: {mem_rdata, lo} if split, else {0, mem_rdata}; shift right by 8*off; take low byte/half/word.
REQ-029 Load extension: 000 word, 001/011 sign-extend, 010/100 zero-extend.
REQ-030 Latency: accept at cycle T -> rsp_valid at T+2 aligned, T+3 split, T+1 error.
REQ-031 Outside BEAT0/BEAT1: mem_en = 0, mem_we = 0, mem_be = 0.
REQ-032 Consumer always accepts rsp; no response backpressure.
REQ-033 req_valid outside IDLE is ignored; no request is lost, because req_ready = 0.

Reset
REQ-034 Reset edge: state = IDLE, lo = 0, latched request = 0.
REQ-035 Outputs after reset: req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_en = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
REQ-036 Reset in BEAT0, BEAT1 or DONE aborts the access; no rsp_valid is produced for it, and a split store may be left half-written.

Verification
REQ-037 Store byte 0xA5 at addr 0x102 -> one beat: mem_addr 0x40, be 0100, wdata 0x00A50000; rsp_valid at T+2, rsp_err = 0.
REQ-038 Word 0x80FF7F01 at word 0x40; load half (001) at 0x101, then half unsigned (010) at 0x101 -> rsp_rdata 0xFFFFFF7F, then 0x0000FF7F.
REQ-039 Store word 0x11223344 at 0x103 -> beat0: addr 0x40, be 1000, wdata 0x44000000; beat1: addr 0x41, be 0111, wdata 0x00112233; rsp_valid at T+3.
REQ-040 Split load word at 0xFFFFFFFE -> second beat mem_addr wraps to 0x0, and result = {word0[15:0], word3FFFFFFF[31:16]}.
REQ-041 dmtype 110, or SPLIT_EN = 0 with a word load at 0x1 -> no mem_en, rsp_valid at T+1, rsp_err = 1, rsp_rdata = 0.
REQ-042 rstn low during BEAT1 of a split load -> next cycle IDLE, req_ready = 1, no rsp_valid; a following aligned load completes normally.

Source files
------------

// File: rtl/dm_access_unit.sv
// dm_access_unit: data-memory access unit between the pipeline and a word-wide SRAM.
// Loads and stores of byte/half/word size are turned into one or two word beats.
// A misaligned access that crosses a word boundary becomes two beats, or it
// completes with an error when splitting is disabled. Invalid dmtype codes also
// complete with an error and never touch memory.
module dm_access_unit #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_dmtype,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // Request captured at accept time; decoding below works from these copies.
    logic        lat_we;
    logic [2:0]  lat_dmtype;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] lo;

    // Size mask (word/half/byte) placed on an 8-lane window starting at the byte offset.
    function automatic logic [7:0] lane_mask_f(input logic [2:0] dmtype, input logic [1:0] off);
        logic [3:0] size_mask;
        case (dmtype)
            3'b000:         size_mask = 4'b1111;
            3'b001, 3'b010: size_mask = 4'b0011;
            3'b011, 3'b100: size_mask = 4'b0001;
            default:        size_mask = 4'b0000;
        endcase
        return {4'b0000, size_mask} << off;
    endfunction

    // Codes 101..111 are not defined.
    function automatic logic type_ok_f(input logic [2:0] dmtype);
        return dmtype <= 3'b100;
    endfunction

    // Decode of the incoming request, used only for the accept decision.
    logic [7:0]  req_mask;
    logic        req_bad;

    assign req_mask = lane_mask_f(req_dmtype, req_addr[1:0]);
    assign req_bad  = !type_ok_f(req_dmtype) || ((|req_mask[7:4]) && !SPLIT_EN);

    // Decode of the latched request, drives the beats and the response.
    logic [1:0]  off;
    logic [29:0] w0;
    logic [7:0]  lat_mask;
    logic [63:0] lane_data;
    logic        lat_split;
    logic        lat_bad;

    assign off       = lat_addr[1:0];
    assign w0        = lat_addr[31:2];
    assign lat_mask  = lane_mask_f(lat_dmtype, off);
    assign lane_data = {32'd0, lat_wdata} << {off, 3'b000};
    assign lat_split = |lat_mask[7:4];
    assign lat_bad   = !type_ok_f(lat_dmtype) || (lat_split && !SPLIT_EN);

    // Load path: assemble the bytes of interest at bit 0, then extend by type.
    logic [63:0] raw_data;
    logic [31:0] load_word;
    logic [31:0] load_ext;

    assign raw_data  = lat_split ? {mem_rdata, lo} : {32'd0, mem_rdata};
    assign load_word = 32'(raw_data >> {off, 3'b000});

    // Sign- or zero-extend the selected byte/half/word.
    always_comb begin
        load_ext = 32'd0;
        case (lat_dmtype)
            3'b000:  load_ext = load_word;
            3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
            3'b010:  load_ext = {16'd0, load_word[15:0]};
            3'b011:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
            3'b100:  load_ext = {24'd0, load_word[7:0]};
            default: load_ext = 32'd0;
        endcase
    end

    // State register, request latch and low-beat read capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rstn) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_dmtype <= 3'd0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lo         <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                lat_we     <= req_we;
                lat_dmtype <= req_dmtype;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
            end
            if (state == BEAT1) begin
                lo <= mem_rdata;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        rsp_rdata  = 32'd0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = 30'd0;
        mem_wdata  = 32'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_bad ? DONE : BEAT0;
                end
            end
            BEAT0: begin
                mem_en     = 1'b1;
                mem_we     = lat_we;
                mem_addr   = w0;
                mem_be     = lat_mask[3:0];
                mem_wdata  = lane_data[31:0];
                state_next = lat_split ? BEAT1 : DONE;
            end
            BEAT1: begin
                mem_en     = 1'b1;
                mem_we     = lat_we;
                mem_addr   = w0 + 30'd1;
                mem_be     = lat_mask[7:4];
                mem_wdata  = lane_data[63:32];
                state_next = DONE;
            end
            DONE: begin
                rsp_valid  = 1'b1;
                rsp_err    = lat_bad;
                rsp_rdata  = (lat_we || lat_bad) ? 32'd0 : load_ext;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
